// File: rtl/ins_fetch_seq.sv
// Fetch/decode sequencer: issues instruction reads at the PC, decodes the returned word
// and emits a one-cycle execute strobe. HALT and fetch faults are sticky until reset.
module ins_fetch_seq #(
    parameter int          ACK_TIMEOUT = 16,
    parameter logic [4:0]  HALT_OP     = 5'b11111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] ins_address,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [4:0]  opcode,
    output logic [31:0] imm_ext,
    output logic        en_exe_pulse,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       instr_q, instr_d;
    logic [4:0]        opcode_q, opcode_d;
    logic [31:0]       imm_q, imm_d;
    logic [1:0]        fcode_q, fcode_d;
    logic [CNT_W-1:0]  cnt_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            instr_q  <= '0;
            opcode_q <= '0;
            imm_q    <= '0;
            fcode_q  <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            opcode_q <= opcode_d;
            imm_q    <= imm_d;
            fcode_q  <= fcode_d;
        end
    end

    assign cnt_inc = cnt_q + 1'b1;

    // FETCH spends its first cycle (req_q=0) checking alignment of the now-stable PC,
    // so an EXEC-time PC update is seen before any request goes out.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        opcode_d = opcode_q;
        imm_d    = imm_q;
        fcode_d  = fcode_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!req_q) begin
                    if (ins_address[1:0] != 2'b00) begin
                        state_d = S_FAULT;
                        fcode_d = 2'b10;
                    end else begin
                        req_d  = 1'b1;
                        addr_d = ins_address;
                        cnt_d  = '0;
                    end
                end else if (mem_ack) begin
                    instr_d = mem_rdata;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DECODE;
                end else if (cnt_inc == CNT_LIMIT) begin
                    req_d   = 1'b0;
                    cnt_d   = cnt_inc;
                    fcode_d = 2'b01;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DECODE: begin
                opcode_d = instr_q[31:27];
                imm_d    = {{16{instr_q[15]}}, instr_q[15:0]};
                state_d  = (instr_q[31:27] == HALT_OP) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT, S_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req      = req_q;
        mem_addr     = addr_q;
        instr        = instr_q;
        opcode       = opcode_q;
        imm_ext      = imm_q;
        fault_code   = fcode_q;
        en_exe_pulse = (state_q == S_EXEC);
        busy         = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
        halted       = (state_q == S_HALT);
        fault        = (state_q == S_FAULT);
    end

endmodule

// File: tb/tb_ins_fetch_seq.sv
// Bench for ins_fetch_seq: a memory responder pushes expected decode results on each ack,
// and an execute monitor pops and compares them on every en_exe_pulse.
module tb_ins_fetch_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] ins_address;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [4:0]  opcode;
    logic [31:0] imm_ext;
    logic        en_exe_pulse;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;

    ins_fetch_seq #(.ACK_TIMEOUT(16), .HALT_OP(5'b11111)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .ins_address  (ins_address),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .instr        (instr),
        .opcode       (opcode),
        .imm_ext      (imm_ext),
        .en_exe_pulse (en_exe_pulse),
        .busy         (busy),
        .halted       (halted),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          ack_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          pulse_times[$];
    logic [31:0] mem [0:63];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          ack_delay;
    bit          ack_enable;
    int          req_cycles;
    int          pulse_cnt;
    localparam logic [31:0] HALT_WORD = 32'hF800_0000;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: acks after ack_delay request cycles, checks the request address.
    initial begin
        int wait_cnt;
        exp_t e;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
        forever begin
            @(negedge clk);
            if (mem_req && !reset) begin
                req_cycles++;
                if (ack_enable && wait_cnt >= ack_delay) begin
                    n_checks++;
                    if (mem_addr !== ins_address) begin
                        n_fail++;
                        $display("FAIL mem_addr: got %h expected %h", mem_addr, ins_address);
                    end
                    mem_ack   = 1'b1;
                    mem_rdata = mem[ins_address[7:2]];
                    if (mem_rdata[31:27] != 5'b11111) begin
                        e.word    = mem_rdata;
                        e.ack_cyc = cyc;
                        exp_q.push_back(e);
                    end
                    $display("ack  cyc=%0d addr=%h data=%h", cyc, mem_addr, mem_rdata);
                end else begin
                    mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Execute monitor: scoreboard pop, pulse spacing and latency, PC model update.
    initial begin
        bit prev;
        exp_t e;
        logic [31:0] exp_imm;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
            end else if (en_exe_pulse) begin
                pulse_cnt++;
                pulse_times.push_back(cyc);
                n_checks++;
                if (prev) begin
                    n_fail++;
                    $display("FAIL pulse_consecutive: pulse high two cycles at cyc=%0d", cyc);
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: pulse at cyc=%0d with no pending fetch", cyc);
                end else begin
                    e = exp_q.pop_front();
                    exp_imm = {{16{e.word[15]}}, e.word[15:0]};
                    n_checks += 4;
                    if (opcode !== e.word[31:27]) begin
                        n_fail++;
                        $display("FAIL opcode: got %b expected %b", opcode, e.word[31:27]);
                    end
                    if (imm_ext !== exp_imm) begin
                        n_fail++;
                        $display("FAIL imm_ext: got %h expected %h", imm_ext, exp_imm);
                    end
                    if (instr !== e.word) begin
                        n_fail++;
                        $display("FAIL instr: got %h expected %h", instr, e.word);
                    end
                    if (cyc - e.ack_cyc != 2) begin
                        n_fail++;
                        $display("FAIL ack_to_pulse: got %0d cycles expected 2", cyc - e.ack_cyc);
                    end
                    $display("exec cyc=%0d op=%b imm=%h", cyc, opcode, imm_ext);
                    ins_address = (e.word[31:27] == 5'b11000) ? exp_imm : ins_address + 32'd4;
                end
            end
            prev = en_exe_pulse;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        pulse_times.delete();
        pulse_cnt  = 0;
        req_cycles = 0;
        ack_enable = 1'b1;
        ack_delay  = 0;
        reset = 1'b0;
    endtask

    task automatic wait_stop(input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted || fault) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run = 1'b0;
        ins_address = '0;
        @(negedge clk);
        n_checks++;
        if ({mem_req, en_exe_pulse, busy, halted, fault} !== 5'b0 || fault_code !== 2'b00 ||
            mem_addr !== 32'h0 || instr !== 32'h0 || opcode !== 5'h0 || imm_ext !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b pulse=%b busy=%b halt=%b fault=%b code=%b addr=%h instr=%h op=%b imm=%h expected all 0",
                     mem_req, en_exe_pulse, busy, halted, fault, fault_code, mem_addr, instr, opcode, imm_ext);
        end
        do_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: busy=%b req=%b expected 0 0 with run=0", busy, mem_req);
        end
        $display("test_reset done");
    endtask

    task automatic test_jmp_halt();
        bit hit;
        do_reset();
        mem[0] = 32'hC000_0010;
        mem[4] = HALT_WORD;
        ack_delay = 1;
        ins_address = 32'h0;
        run = 1'b1;
        wait_stop(60, hit);
        n_checks++;
        if (!hit || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL jmp_halt_reached: halted=%b expected 1", halted);
        end
        n_checks++;
        if (pulse_cnt != 1 || req_cycles != 4) begin
            n_fail++;
            $display("FAIL jmp_counts: pulses=%0d req_cycles=%0d expected 1 4", pulse_cnt, req_cycles);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || opcode !== 5'b11111 || instr !== HALT_WORD ||
            imm_ext !== 32'h0 || pulse_cnt != 1) begin
            n_fail++;
            $display("FAIL halt_sticky: req=%b busy=%b op=%b instr=%h imm=%h pulses=%0d expected 0 0 11111 %h 0 1",
                     mem_req, busy, opcode, instr, imm_ext, pulse_cnt, HALT_WORD);
        end
        $display("test_jmp_halt done");
    endtask

    task automatic test_back_to_back();
        bit hit;
        do_reset();
        mem[0] = 32'h0800_8004;
        mem[1] = 32'h1000_7FFF;
        mem[2] = 32'h2001_FFFF;
        mem[3] = HALT_WORD;
        ack_delay = 0;
        ins_address = 32'h0;
        run = 1'b1;
        wait_stop(60, hit);
        n_checks++;
        if (!hit || halted !== 1'b1 || pulse_cnt != 3) begin
            n_fail++;
            $display("FAIL b2b_done: halted=%b pulses=%0d expected 1 3", halted, pulse_cnt);
        end else begin
            n_checks++;
            if (pulse_times[1] - pulse_times[0] != 4 || pulse_times[2] - pulse_times[1] != 4) begin
                n_fail++;
                $display("FAIL b2b_spacing: gaps %0d %0d expected 4 4",
                         pulse_times[1] - pulse_times[0], pulse_times[2] - pulse_times[1]);
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_timeout();
        bit hit;
        do_reset();
        ack_enable = 1'b0;
        ins_address = 32'h0;
        run = 1'b1;
        wait_stop(60, hit);
        n_checks++;
        if (!hit || fault !== 1'b1 || fault_code !== 2'b01 || mem_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fault: fault=%b code=%b req=%b busy=%b expected 1 01 0 0",
                     fault, fault_code, mem_req, busy);
        end
        n_checks++;
        if (req_cycles != 16) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d request cycles expected 16", req_cycles);
        end
        ack_enable = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (fault !== 1'b1 || mem_req !== 1'b0 || req_cycles != 16 || pulse_cnt != 0) begin
            n_fail++;
            $display("FAIL fault_sticky: fault=%b req=%b req_cycles=%0d pulses=%0d expected 1 0 16 0",
                     fault, mem_req, req_cycles, pulse_cnt);
        end
        $display("test_timeout done");
    endtask

    task automatic test_ack_at_limit();
        bit hit;
        do_reset();
        mem[0] = 32'h0800_0001;
        mem[1] = HALT_WORD;
        ack_delay = 15;
        ins_address = 32'h0;
        run = 1'b1;
        wait_stop(120, hit);
        n_checks++;
        if (!hit || halted !== 1'b1 || fault !== 1'b0 || fault_code !== 2'b00 || pulse_cnt != 1) begin
            n_fail++;
            $display("FAIL ack_at_limit: halted=%b fault=%b code=%b pulses=%0d expected 1 0 00 1",
                     halted, fault, fault_code, pulse_cnt);
        end
        $display("test_ack_at_limit done");
    endtask

    task automatic test_misaligned();
        bit hit;
        do_reset();
        ins_address = 32'h6;
        run = 1'b1;
        wait_stop(20, hit);
        repeat (3) @(negedge clk);
        n_checks++;
        if (!hit || fault !== 1'b1 || fault_code !== 2'b10 || mem_req !== 1'b0 || req_cycles != 0) begin
            n_fail++;
            $display("FAIL misaligned: fault=%b code=%b req=%b req_cycles=%0d expected 1 10 0 0",
                     fault, fault_code, mem_req, req_cycles);
        end
        $display("test_misaligned done");
    endtask

    task automatic test_run_drop();
        bit seen;
        do_reset();
        mem[0] = 32'h0800_0002;
        mem[1] = 32'h0800_0003;
        ack_delay = 3;
        ins_address = 32'h0;
        run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        run = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (!seen || pulse_cnt != 1 || busy !== 1'b0 || mem_req !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL run_drop: seen=%b pulses=%0d busy=%b req=%b halt=%b fault=%b expected 1 1 0 0 0 0",
                     seen, pulse_cnt, busy, mem_req, halted, fault);
        end
        $display("test_run_drop done");
    endtask

    task automatic test_async_reset();
        bit seen;
        do_reset();
        ack_enable = 1'b0;
        ins_address = 32'h0;
        run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (!seen || mem_req !== 1'b0 || busy !== 1'b0 || en_exe_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: seen=%b req=%b busy=%b pulse=%b expected 1 0 0 0",
                     seen, mem_req, busy, en_exe_pulse);
        end
        do_reset();
        $display("test_async_reset done");
    endtask

    initial begin
        reset = 1'b1;
        run = 1'b0;
        ins_address = '0;
        ack_enable = 1'b1;
        ack_delay = 0;
        req_cycles = 0;
        pulse_cnt = 0;
        for (int i = 0; i < 64; i++) mem[i] = HALT_WORD;
        test_reset();
        test_jmp_halt();
        test_back_to_back();
        test_timeout();
        test_ack_at_limit();
        test_misaligned();
        test_run_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
